cam_alloc: RTL
==============

Name: cam_alloc

Overview:
- Parametrised content-addressable memory with per-entry valid bits and hardware slot allocation.
- Supports multiple masked search ports, each with a registered result (hit, lowest hit index, multi-hit flag).
- Inserts self-allocate the lowest free entry, or evict round-robin when full; entries can also be invalidated or flushed.
- Used as the tag/lookup store for buffers that need associative search plus managed occupancy.

Parameters:
- DATA, 16, key width in bits.
- DEPTH, 16, number of entries (power of two, >=2).
- SRCH, 2, number of independent search ports.
- ADDR, $clog2(DEPTH), entry index width (derived; do not override).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous active-high reset.
- ins_valid  in  1  insert request this cycle.
- ins_key  in  DATA  key to store.
- ins_idx  out  ADDR  entry written by this cycle's insert (combinational).
- ins_evict  out  1  this cycle's insert overwrites a valid entry (combinational).
- inv_valid  in  1  invalidate request.
- inv_idx  in  ADDR  entry to invalidate.
- flush  in  1  invalidate all entries.
- s_valid  in  SRCH  per-port search request.
- s_key  in  SRCH x DATA  search key.
- s_mask  in  SRCH x DATA  1 = bit ignored in compare.
- r_valid  out  SRCH  result valid (1 cycle after s_valid).
- r_hit  out  SRCH  at least one valid entry matched.
- r_idx  out  SRCH x ADDR  lowest matching index; 0 when no hit.
- r_multi  out  SRCH  two or more entries matched.
- count  out  ADDR+1  number of valid entries.
- full  out  1  count == DEPTH.

Behaviour:
- Reset (async, level):
  - all valid bits 0, keys 0, victim pointer 0, count 0;
  - r_valid/r_hit/r_multi 0, r_idx 0, full 0.
  - Reset asserted mid-operation discards any in-flight search result; the next r_valid after deassertion corresponds only to searches issued after deassertion.
- Match rule: entry e matches port p iff valid[e] and ((key[e] ^ s_key[p]) & ~s_mask[p]) == 0. An all-ones mask matches every valid entry.
- Search latency: exactly 1 cycle.
  - Compare uses entry state at the start of the cycle, so same-cycle inserts, invalidates and flushes are not visible.
  - r_* registered; r_valid = registered s_valid; r_hit/r_idx/r_multi forced 0 when the port's s_valid was 0.
  - Ports fully independent; any combination per cycle.
- Allocation, computed combinationally from the current valid vector:
  - not full: ins_idx = lowest index with valid==0, ins_evict = 0;
  - full: ins_idx = victim pointer, ins_evict = 1.
  - ins_idx/ins_evict are driven even when ins_valid=0 (preview); the state changes only when ins_valid=1.
- Insert commit (posedge, ins_valid=1): key[ins_idx] <= ins_key, valid[ins_idx] <= 1.
- Victim pointer:
  - advances (mod DEPTH, wrap DEPTH-1 -> 0) only on an evicting insert;
  - otherwise holds;
  - flush resets it to 0.
- Invalidate (inv_valid=1): valid[inv_idx] <= 0; keys untouched. Invalidating an already invalid entry has no effect.
- Simultaneous events, in priority order:
  - flush: all valid bits to 0, same-cycle insert and invalidate ignored, count <= 0.
  - insert and invalidate on the same index: insert wins, entry ends valid with new key.
  - insert and invalidate on different indices: both take effect.
  - when full with a same-cycle invalidate, allocation still uses the pre-invalidate valid vector (evicts the victim).
- count: next = popcount of next valid vector (or an equivalent incremental update); must never exceed DEPTH or underflow. full = (count == DEPTH), registered with count.
- No backpressure; inserts are always accepted.

Test Plan:
- Reset, then insert keys 0x1111, 0x2222, 0x3333 on consecutive cycles -> ins_idx 0, 1, 2; ins_evict 0; count 3.
- Search port 0 for 0x2222 with mask 0 -> one cycle later r_valid=1, r_hit=1, r_idx=1, r_multi=0. Port 1 same cycle searches 0x4444 -> r_hit=0, r_idx=0.
- Search 0x1100 with mask 0x00FF after the above -> r_hit=1, r_idx=0, r_multi=0. Then insert 0x11AA and repeat -> r_idx=0, r_multi=1.
- Fill all 16 entries -> full=1. Three more inserts -> ins_idx 0, 1, 2 with ins_evict=1, victim pointer wraps correctly after 16 evictions, count stays 16.
- Invalidate index 5 while full -> next cycle count 15, full=0; next insert gets ins_idx 5. Same-cycle insert + invalidate on idx 5 -> entry 5 valid with new key, count unchanged.
- Flush asserted with a simultaneous insert -> count 0, all searches miss, next insert gets ins_idx 0. Reset asserted while s_valid=1 -> r_valid 0 after release.

Source files
------------

// File: rtl/cam_alloc.sv
// cam_alloc: associative tag store with per-entry valid bits, hardware slot
// allocation (lowest free entry, round-robin eviction when full), entry
// invalidate / global flush, and SRCH independent masked search ports whose
// results are registered one cycle after the request.
//
// Request semantics: every *_valid input is a one-cycle request qualifier.
// There is no ready/backpressure; a request asserted on a rising edge is
// consumed on that edge. ins_idx/ins_evict are a combinational preview of
// where an insert would land this cycle and are meaningful even when
// ins_valid is low. Each r_valid pulses exactly one cycle after its s_valid.
module cam_alloc #(
    parameter int DATA  = 16,
    parameter int DEPTH = 16,
    parameter int SRCH  = 2,
    parameter int ADDR  = $clog2(DEPTH)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      ins_valid,
    input  logic [DATA-1:0]           ins_key,
    output logic [ADDR-1:0]           ins_idx,
    output logic                      ins_evict,
    input  logic                      inv_valid,
    input  logic [ADDR-1:0]           inv_idx,
    input  logic                      flush,
    input  logic [SRCH-1:0]           s_valid,
    input  logic [SRCH-1:0][DATA-1:0] s_key,
    input  logic [SRCH-1:0][DATA-1:0] s_mask,
    output logic [SRCH-1:0]           r_valid,
    output logic [SRCH-1:0]           r_hit,
    output logic [SRCH-1:0][ADDR-1:0] r_idx,
    output logic [SRCH-1:0]           r_multi,
    output logic [ADDR:0]             count,
    output logic                      full
);

    // Occupancy value that means "every entry valid".
    localparam logic [ADDR:0] DEPTH_CNT = (ADDR+1)'(DEPTH);

    // Entry state.
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_d;
    logic [DATA-1:0]  key_q [DEPTH];

    // Round-robin eviction pointer. DEPTH is a power of two, so the ADDR-bit
    // increment wraps DEPTH-1 -> 0 without an explicit compare.
    logic [ADDR-1:0]  victim_q;
    logic [ADDR-1:0]  victim_d;

    // Occupancy, kept registered alongside full.
    logic [ADDR:0]    count_q;
    logic [ADDR:0]    count_d;
    logic             full_q;

    // Allocation helpers.
    logic             all_valid;
    logic             key_we;

    // Per-port match vectors against the entry state at the start of the cycle.
    logic [DEPTH-1:0] match [SRCH];

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic logic [ADDR-1:0] lowest_set(input logic [DEPTH-1:0] vec);
        logic [ADDR-1:0] idx;
        idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = ADDR'(i);
            end
        end
        return idx;
    endfunction

    // Number of set bits, sized to hold DEPTH.
    function automatic logic [ADDR:0] popcount(input logic [DEPTH-1:0] vec);
        logic [ADDR:0] cnt;
        cnt = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt = cnt + {{ADDR{1'b0}}, vec[i]};
        end
        return cnt;
    endfunction

    // True when two or more bits are set: clearing the lowest set bit
    // leaves something behind.
    function automatic logic multi_set(input logic [DEPTH-1:0] vec);
        return (vec & (vec - DEPTH'(1))) != '0;
    endfunction

    assign all_valid = &valid_q;
    assign key_we    = ins_valid && !flush;

    // Slot preview: lowest free entry, or the victim when the store is full.
    // Uses the pre-invalidate valid vector, so a same-cycle invalidate never
    // redirects an insert that would otherwise evict.
    always_comb begin
        ins_evict = all_valid;
        ins_idx   = all_valid ? victim_q : lowest_set(~valid_q);
    end

    // Next entry-valid vector, victim pointer and occupancy. Flush wins over
    // everything; otherwise invalidate is applied first so that an insert to
    // the same index leaves the entry valid.
    always_comb begin
        valid_d  = valid_q;
        victim_d = victim_q;
        if (flush) begin
            valid_d  = '0;
            victim_d = '0;
        end else begin
            if (inv_valid) begin
                valid_d[inv_idx] = 1'b0;
            end
            if (ins_valid) begin
                valid_d[ins_idx] = 1'b1;
                if (ins_evict) begin
                    victim_d = victim_q + ADDR'(1);
                end
            end
        end
        count_d = popcount(valid_d);
    end

    // Valid bits, victim pointer, count and full.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= '0;
            victim_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            victim_q <= victim_d;
            count_q  <= count_d;
            full_q   <= (count_d == DEPTH_CNT);
        end
    end

    // Key storage: written only by a committed (non-flushed) insert;
    // invalidate leaves keys in place.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int e = 0; e < DEPTH; e++) begin
                key_q[e] <= '0;
            end
        end else if (key_we) begin
            key_q[ins_idx] <= ins_key;
        end
    end

    // Masked compare of every valid entry against every search port.
    always_comb begin
        for (int p = 0; p < SRCH; p++) begin
            for (int e = 0; e < DEPTH; e++) begin
                match[p][e] = valid_q[e] &&
                              (((key_q[e] ^ s_key[p]) & ~s_mask[p]) == '0);
            end
        end
    end

    // Registered search results; hit/idx/multi are held at 0 for idle ports
    // and reset discards any search in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            r_hit   <= '0;
            r_idx   <= '0;
            r_multi <= '0;
        end else begin
            for (int p = 0; p < SRCH; p++) begin
                r_valid[p] <= s_valid[p];
                r_hit[p]   <= s_valid[p] && (|match[p]);
                r_idx[p]   <= s_valid[p] ? lowest_set(match[p]) : '0;
                r_multi[p] <= s_valid[p] && multi_set(match[p]);
            end
        end
    end

    assign count = count_q;
    assign full  = full_q;

endmodule
